reg_cmd_ctrl: RTL
=================

# reg_cmd_ctrl

Command-driven controller for a single `regstr`-style data register: the block that drives the register's `we`/`inc`/clear inputs and reads back its output. It accepts write, increment, clear and read commands over a valid/ready handshake and keeps a shadow copy of the expected register value. It checks the register's read-back against the shadow after every command and returns the result on a response handshake. It sits between a command source (sequencer or host bus bridge) and one register instance.

## Interface
- `WIDTH`, 32: data width of register, shadow and response.
- `ERRW`, 8: width of the saturating error counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_s`  in  1  synchronous reset, active-high; sampled only on rising `clk`.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  operation: 00 read, 01 write, 10 increment, 11 clear.
- `cmd_data`  in  WIDTH  write value for op 01; for op 10, bits [3:0] give the repeat count minus 1; ignored for ops 00 and 11.
- `reg_we`  out  1  register write enable.
- `reg_inc`  out  1  register increment.
- `reg_clr`  out  1  register synchronous clear, driven to the register's `rst_s`-equivalent input.
- `reg_din`  out  WIDTH  register write data.
- `reg_dout`  in  WIDTH  register output.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  WIDTH  sampled `reg_dout`.
- `rsp_err`  out  1  1 when `reg_dout` differed from the shadow.
- `err_cnt`  out  ERRW  count of mismatches; saturates at all-ones.

## Operation
- FSM states: IDLE, ISSUE, CHECK, RESP.
- `cmd_ready` = (state == IDLE). A command is accepted on a cycle where `cmd_valid && cmd_ready`. The block latches op, data and repeat count (`cmd_data[3:0]+1`, range 1..16).
- IDLE transitions:
  - On accept of op 00 → CHECK.
  - On accept of any other op → ISSUE.
- ISSUE asserts exactly one strobe per cycle:
  - write: `reg_we`=1, `reg_din`=latched data, for 1 cycle; shadow ← data.
  - clear: `reg_clr`=1 for 1 cycle; shadow ← 0.
  - increment: `reg_inc`=1 for N consecutive cycles; shadow ← shadow+1 each cycle, modulo 2^WIDTH (all-ones wraps to 0).
  - After the last strobe cycle → CHECK.
- Strobes are mutually exclusive and are 0 outside ISSUE. `reg_din` is 0 when `reg_we`=0.
- CHECK (one cycle):
  - `rsp_data` ← `reg_dout`.
  - `rsp_err` ← (`reg_dout` != shadow).
  - If mismatch and `err_cnt` is not all-ones, `err_cnt` increments.
  - Next state is RESP.
- RESP: `rsp_valid`=1. `rsp_data` and `rsp_err` are held stable until `rsp_ready`=1. On a cycle with `rsp_valid && rsp_ready` → IDLE.
- Reset values: state IDLE, shadow 0, `err_cnt` 0. All outputs are 0 (`cmd_ready` reads 1 after the first post-reset edge). The register shares `rst_s`, so shadow and register agree at 0 after reset.
- `rst_s` mid-command abandons the command: no further strobes, no response, `err_cnt` cleared.
- `err_cnt` is never cleared except by `rst_s`.

## Timing
- Accept at edge k (IDLE). The register samples a strobe at the edge that ends its ISSUE cycle, so `reg_dout` is valid in the following CHECK cycle.
- Write or clear: strobe in cycle k+1, CHECK in k+2, `rsp_valid` first high in cycle k+3.
- Increment with N repeats: strobes in k+1..k+N, CHECK in k+N+1, `rsp_valid` in k+N+2.
- Read: CHECK in k+1, `rsp_valid` in k+2.
- `cmd_ready` rises in the cycle after the response handshake; minimum command spacing is latency+1 cycles.
- No combinational path from `cmd_valid` or `rsp_ready` to any output.

## Test plan
- Reset 3 cycles, then issue a read → `rsp_valid` 2 cycles after accept, `rsp_data`=0, `rsp_err`=0, `err_cnt`=0.
- Write 0x0000_00A5 → `reg_we` high for exactly 1 cycle with `reg_din`=0xA5; `rsp_valid` 3 cycles after accept with `rsp_data`=0xA5, `rsp_err`=0.
- Write 0xFFFF_FFFE, then increment with `cmd_data[3:0]`=2 → `reg_inc` high for 3 consecutive cycles; response `rsp_data`=0x0000_0001, `rsp_err`=0 (wrap).
- Hold `rsp_ready` low for 5 cycles after a clear → `rsp_valid`, `rsp_data`=0 and `rsp_err` stable throughout; `cmd_ready` stays 0 until 1 cycle after the handshake.
- Force `reg_dout`=0x5 in CHECK after a write of 0x3 → `rsp_err`=1, `err_cnt`=1. Repeat 300 times → `err_cnt` saturates at 0xFF.
- Assert `rst_s` during the 2nd strobe of a 16-repeat increment → strobes stop the next cycle, no `rsp_valid`, shadow and `err_cnt` are 0, and `cmd_ready`=1 after reset releases.

Source files
------------

// File: rtl/reg_cmd_ctrl_if.sv
// Command and response handshake bundle for reg_cmd_ctrl.
// The command source drives through master; the controller uses slave.
interface reg_cmd_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Command-driven controller for one data register. Issues write/increment/
// clear strobes, keeps a shadow of the expected register contents, compares
// the read-back against it after every command and returns the result.
module reg_cmd_ctrl #(
    parameter int WIDTH = 32,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst_s,
    reg_cmd_ctrl_if.slave    bus,
    output logic             reg_we,
    output logic             reg_inc,
    output logic             reg_clr,
    output logic [WIDTH-1:0] reg_din,
    input  logic [WIDTH-1:0] reg_dout,
    output logic [ERRW-1:0]  err_cnt
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [3:0]       cnt_reg;       // remaining increment strobes minus one
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_err_reg;
    logic [ERRW-1:0]  err_cnt_reg;

    logic accept;
    logic strobe_we;
    logic strobe_inc;
    logic strobe_clr;
    logic mismatch;

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and strobe decode; strobes depend only on registered state.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        strobe_we  = 1'b0;
        strobe_inc = 1'b0;
        strobe_clr = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = (bus.cmd_op == OP_READ) ? CHECK : ISSUE;
                end
            end
            ISSUE: begin
                case (op_reg)
                    OP_WRITE: begin
                        strobe_we  = 1'b1;
                        state_next = CHECK;
                    end
                    OP_CLEAR: begin
                        strobe_clr = 1'b1;
                        state_next = CHECK;
                    end
                    OP_INC: begin
                        strobe_inc = 1'b1;
                        if (cnt_reg == 4'd0) begin
                            state_next = CHECK;
                        end
                    end
                    default: begin
                        state_next = CHECK;
                    end
                endcase
            end
            CHECK: begin
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the command fields and count down increment repeats.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            op_reg   <= OP_READ;
            data_reg <= '0;
            cnt_reg  <= 4'd0;
        end else if (accept) begin
            op_reg   <= bus.cmd_op;
            data_reg <= bus.cmd_data;
            cnt_reg  <= bus.cmd_data[3:0];
        end else if (strobe_inc) begin
            cnt_reg  <= cnt_reg - 4'd1;
        end
    end

    // Shadow tracks what the register should hold after each strobe.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            shadow_reg <= '0;
        end else if (strobe_we) begin
            shadow_reg <= data_reg;
        end else if (strobe_clr) begin
            shadow_reg <= '0;
        end else if (strobe_inc) begin
            shadow_reg <= shadow_reg + WIDTH'(1);
        end
    end

    assign mismatch = (reg_dout != shadow_reg);

    // Capture the read-back in CHECK and hold it through RESP.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else if (state_reg == CHECK) begin
            rsp_data_reg <= reg_dout;
            rsp_err_reg  <= mismatch;
        end
    end

    // Saturating mismatch counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            err_cnt_reg <= '0;
        end else if ((state_reg == CHECK) && mismatch && (err_cnt_reg != {ERRW{1'b1}})) begin
            err_cnt_reg <= err_cnt_reg + ERRW'(1);
        end
    end

    // Write data is gated so the bus reads zero whenever no write strobe is up.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_din
            assign reg_din[gi] = data_reg[gi] & strobe_we;
        end
    endgenerate

    assign reg_we        = strobe_we;
    assign reg_inc       = strobe_inc;
    assign reg_clr       = strobe_clr;
    assign err_cnt       = err_cnt_reg;
    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;

endmodule
